// File: rtl/imem_fetch.sv
// Instruction memory with a pipelined fetch port and a 2-entry in-order response queue.
// Define IMEM_FETCH_FAULT_EN to flag misaligned/out-of-range fetches and drop such loads.
module imem_fetch #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 64,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_fault,
  input  logic              wr_en,
  input  logic [31:0]       wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [DATA_W-1:0] NOP = DATA_W'(32'h00000013);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_idx;
  logic [AW-1:0]     wr_idx;
  logic              rd_bad;
  logic              wr_bad;
  logic              wr_go;
  logic [DATA_W-1:0] rd_word;

  assign rd_idx = req_addr[AW+1:2];
  assign wr_idx = wr_addr[AW+1:2];

`ifdef IMEM_FETCH_FAULT_EN
  assign rd_bad = (req_addr[1:0] != 2'b00) || (req_addr[31:AW+2] != '0);
  assign wr_bad = (wr_addr[1:0] != 2'b00) || (wr_addr[31:AW+2] != '0);
`else
  logic unused_addr_bits;
  assign rd_bad = 1'b0;
  assign wr_bad = 1'b0;
  assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0], wr_addr[31:AW+2], wr_addr[1:0]};
`endif

  // Loads are gated combinationally so the array itself carries no reset.
  assign wr_go = wr_en && !wr_bad && !reset;

  always_ff @(posedge clk) begin
    if (wr_go) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_word = rd_bad ? NOP : mem[rd_idx];

  logic              ready_en;
  logic              accept;
  logic              pop;
  logic              push_v;
  logic [DATA_W-1:0] push_d;
  logic              push_f;
  logic              inflight;
  logic [1:0]        occ;
  logic [1:0]        load;
  logic [1:0]        settled;
  logic [DATA_W-1:0] q_d0;
  logic [DATA_W-1:0] q_d1;
  logic              q_f0;
  logic              q_f1;

  assign accept = req_valid && req_ready;
  assign pop    = rsp_valid && rsp_ready;

  generate
    if (LATENCY == 2) begin : g_lat2
      logic              st_v;
      logic [DATA_W-1:0] st_d;
      logic              st_f;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          st_v <= 1'b0;
          st_d <= '0;
          st_f <= 1'b0;
        end else begin
          st_v <= accept;
          st_d <= rd_word;
          st_f <= rd_bad;
        end
      end

      assign push_v   = st_v;
      assign push_d   = st_d;
      assign push_f   = st_f;
      assign inflight = st_v;
    end else begin : g_lat1
      assign push_v   = accept;
      assign push_d   = rd_word;
      assign push_f   = rd_bad;
      assign inflight = 1'b0;
    end
  endgenerate

  // A head pop in this cycle frees its slot, which keeps full throughput at either latency.
  assign load      = occ + {1'b0, inflight};
  assign settled   = load - {1'b0, pop};
  assign req_ready = ready_en && (settled < 2'd2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ  <= 2'd0;
      q_d0 <= '0;
      q_f0 <= 1'b0;
      q_d1 <= '0;
      q_f1 <= 1'b0;
    end else begin
      case ({push_v, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            q_d0 <= push_d;
            q_f0 <= push_f;
          end else begin
            q_d1 <= push_d;
            q_f1 <= push_f;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          q_d0 <= q_d1;
          q_f0 <= q_f1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            q_d0 <= push_d;
            q_f0 <= push_f;
          end else begin
            q_d0 <= q_d1;
            q_f0 <= q_f1;
            q_d1 <= push_d;
            q_f1 <= push_f;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = (occ != 2'd0);
  assign rsp_data  = rsp_valid ? q_d0 : '0;
  assign rsp_fault = rsp_valid && q_f0;

endmodule

// File: doc/imem_fetch.md
IMEM_FETCH -- requirements
Module: imem_fetch

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction word width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, number of words, power of two, at least 4.
REQ-003 SHALL have parameter LATENCY, default 1, request-to-response cycles, legal values 1 or 2.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-006 SHALL have port req_valid  input  1  fetch request present.
REQ-007 SHALL have port req_ready  output  1  fetch request accepted this cycle when high with req_valid.
REQ-008 SHALL have port req_addr  input  32  byte address of fetch.
REQ-009 SHALL have port rsp_valid  output  1  response word available.
REQ-010 SHALL have port rsp_ready  input  1  consumer takes response this cycle.
REQ-011 SHALL have port rsp_data  output  DATA_W  fetched instruction word.
REQ-012 SHALL have port rsp_fault  output  1  fetch fault flag, qualified by rsp_valid.
REQ-013 SHALL have port wr_en  input  1  program-load write strobe.
REQ-014 SHALL have port wr_addr  input  32  byte address of load word.
REQ-015 SHALL have port wr_data  input  DATA_W  load word.

Function
REQ-016 SHALL index memory by addr[log2(DEPTH)+1:2] for both read and load.
REQ-017 SHALL accept a request on a rising edge where req_valid and req_ready are both high.
REQ-018 SHALL present an accepted request's response, at the earliest, LATENCY cycles after acceptance.
REQ-019 SHALL buffer responses in a 2-entry in-order output queue; rsp_data, rsp_fault and rsp_valid come from the queue head.
REQ-020 SHALL drive req_ready high only when queue occupancy plus in-flight requests is below 2; req_ready SHALL NOT depend combinationally on req_valid.
REQ-021 SHALL pop the queue head on a rising edge where rsp_valid and rsp_ready are both high; pop and in-flight arrival in one cycle SHALL leave occupancy unchanged.
REQ-022 SHALL hold rsp_data and rsp_fault stable while rsp_valid is high and rsp_ready is low.
REQ-023 SHALL sustain one accepted request per cycle when rsp_ready stays high, for both LATENCY values.
REQ-024 SHALL write wr_data to the indexed word on a rising edge with wr_en high.
REQ-025 SHALL return old data when a request is accepted in the same cycle as a load to the same word.
REQ-026 SHALL drive rsp_data as 0 whenever rsp_valid is low.

Reset
REQ-027 SHALL, while reset is high, force req_ready=0, rsp_valid=0, rsp_fault=0, rsp_data=0, queue occupancy 0, and no in-flight requests.
REQ-028 SHALL discard queued and in-flight requests when reset asserts mid-operation; none SHALL respond after release.
REQ-029 SHALL ignore wr_en while reset is high; memory contents SHALL be preserved across reset.
REQ-030 SHALL raise req_ready on the first rising edge after reset deasserts.

Configuration
REQ-031 SHALL, with IMEM_FETCH_FAULT_EN defined, set rsp_fault=1 and rsp_data=32'h00000013 (NOP) for a request where req_addr[1:0] is not 0 or word index >= DEPTH; such requests SHALL follow normal ordering and latency.
REQ-032 SHALL, with IMEM_FETCH_FAULT_EN defined, drop loads where wr_addr[1:0] is not 0 or the word index is out of range.
REQ-033 SHALL, without IMEM_FETCH_FAULT_EN, tie rsp_fault to 0, ignore address bits [1:0], and wrap the word index modulo DEPTH for reads and loads.

Verification
REQ-034 SHALL cover back-to-back fetches: load 0x0..0x1C with 32'h0000000F<<4k, request 0x0..0x1C back-to-back, rsp_ready=1 -> eight in-order responses, one per cycle, after LATENCY.
REQ-035 SHALL cover backpressure: rsp_ready=0, issue 3 requests -> exactly 2 accepted, req_ready low; rsp_ready=1 -> both drain in order, then the third is accepted.
REQ-036 SHALL cover the fault path with the macro defined: request 0x102 -> rsp_fault=1, rsp_data=32'h00000013; request 0x100 with DEPTH=64 -> rsp_fault=1.
REQ-037 SHALL cover wrap without the macro: load 32'hDEADBEEF at 0x0, request 0x100 with DEPTH=64 -> rsp_data=32'hDEADBEEF, rsp_fault=0.
REQ-038 SHALL cover read-during-write: word 0x10 holds 32'h11111111; load 32'h22222222 and fetch 0x10 in one cycle -> 32'h11111111; next fetch -> 32'h22222222.
REQ-039 SHALL cover mid-operation reset: with 2 responses queued, pulse reset between edges -> rsp_valid=0 immediately, no stale response after release, memory intact.
